// File: rtl/dyn_console_addr_scroll.sv
// Text console stage 01: pixel-to-cell mapping with ring-buffered
// vertical scroll and VRAM address generation, 2-cycle latency.
module dyn_console_addr_scroll #(
  parameter int GLYPH_W  = 16,
  parameter int GLYPH_H  = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int ADDR_W   = 13,
  localparam int COLS = SCREEN_W / GLYPH_W,
  localparam int ROWS = SCREEN_H / GLYPH_H,
  localparam int PW   = $clog2(GLYPH_W),
  localparam int PH   = $clog2(GLYPH_H),
  localparam int RW   = $clog2(ROWS)
) (
  input  logic              px_clk,
  input  logic              reset_n,
  input  logic [25:0]       RGBStr_i,
  output logic [25:0]       RGBStr_o,
  input  logic              scroll_we,
  input  logic [RW-1:0]     scroll_row,
  output logic              scroll_pend,
  output logic              scroll_err,
  output logic [ADDR_W-1:0] addr_vram,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y,
  output logic [PW-1:0]     glyph_x,
  output logic [PH-1:0]     glyph_y,
  output logic              in_text
);

  logic [9:0]    x;
  logic [9:0]    y;
  logic [9-PW:0] col;
  logic [9-PH:0] row;
  logic [10:0]   wsum;
  logic [10:0]   wrow;
  logic          hit;
  logic          frame_start;
  logic          bad_row;

  logic [RW-1:0] scroll_cur;
  logic [RW-1:0] scroll_nxt;

  logic [25:0]   str_a;
  logic [10:0]   wrow_a;
  logic [9-PW:0] col_a;
  logic          hit_a;
  logic [9:0]    px_a;
  logic [9:0]    py_a;
  logic [PW-1:0] gx_a;
  logic [PH-1:0] gy_a;

  assign x   = RGBStr_i[22:13];
  assign y   = RGBStr_i[12:3];
  assign col = x[9:PW];
  assign row = y[9:PH];

  // Both terms are below ROWS inside the text area, so one wrap suffices.
  assign wsum = 11'(row) + 11'(scroll_cur);
  assign wrow = (wsum >= 11'(ROWS)) ? wsum - 11'(ROWS) : wsum;

  assign hit         = (32'(col) < COLS) && (32'(row) < ROWS);
  assign frame_start = (x == 10'd0) && (y == 10'd0);
  assign bad_row     = 32'(scroll_row) >= ROWS;

  // Commit at frame start; a coincident write then re-arms pending.
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      scroll_cur  <= '0;
      scroll_nxt  <= '0;
      scroll_pend <= 1'b0;
      scroll_err  <= 1'b0;
    end else begin
      scroll_err <= scroll_we && bad_row;
      if (frame_start && scroll_pend) begin
        scroll_cur  <= scroll_nxt;
        scroll_pend <= 1'b0;
      end
      if (scroll_we && !bad_row) begin
        scroll_nxt  <= scroll_row;
        scroll_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      str_a  <= '0;
      wrow_a <= '0;
      col_a  <= '0;
      hit_a  <= 1'b0;
      px_a   <= '0;
      py_a   <= '0;
      gx_a   <= '0;
      gy_a   <= '0;
    end else begin
      str_a  <= RGBStr_i;
      wrow_a <= wrow;
      col_a  <= col;
      hit_a  <= hit;
      px_a   <= {col, {PW{1'b0}}};
      py_a   <= {row, {PH{1'b0}}};
      gx_a   <= x[PW-1:0];
      gy_a   <= y[PH-1:0];
    end
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      RGBStr_o  <= '0;
      addr_vram <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
      glyph_x   <= '0;
      glyph_y   <= '0;
      in_text   <= 1'b0;
    end else begin
      RGBStr_o <= str_a;
      pos_x    <= px_a;
      pos_y    <= py_a;
      glyph_x  <= gx_a;
      glyph_y  <= gy_a;
      in_text  <= hit_a;
      if (hit_a)
        addr_vram <= ADDR_W'(32'(wrow_a) * COLS + 32'(col_a));
    end
  end

endmodule
